// File: rtl/stage_sequencer_if.sv
// Control bundle between the pipeline sequencer and the datapath.
// The sequencer uses the slave modport, the datapath or driver uses master.
interface stage_sequencer_if #(
  parameter int unsigned COUNT_WIDTH = 32
);
  logic                   start;
  logic                   run_en;
  logic                   mem_busy;
  logic                   halt_req;

  logic                   pipe_clear;
  logic                   if_id_we;
  logic                   id_ex_we;
  logic                   ex_mem_we;
  logic                   mem_wb_we;
  logic                   wb_if_we;
  logic                   ram_we;
  logic                   reg_we;
  logic                   halted;
  logic                   stall_error;
  logic [3:0]             state;
  logic [COUNT_WIDTH-1:0] retired_count;

  modport master (
    output start,
    output run_en,
    output mem_busy,
    output halt_req,
    input  pipe_clear,
    input  if_id_we,
    input  id_ex_we,
    input  ex_mem_we,
    input  mem_wb_we,
    input  wb_if_we,
    input  ram_we,
    input  reg_we,
    input  halted,
    input  stall_error,
    input  state,
    input  retired_count
  );

  modport slave (
    input  start,
    input  run_en,
    input  mem_busy,
    input  halt_req,
    output pipe_clear,
    output if_id_we,
    output id_ex_we,
    output ex_mem_we,
    output mem_wb_we,
    output wb_if_we,
    output ram_we,
    output reg_we,
    output halted,
    output stall_error,
    output state,
    output retired_count
  );
endinterface

// File: rtl/stage_sequencer.sv
// Multi-cycle pipeline sequencer: one instruction walks FETCH..COMMIT.
// Define STAGE_SEQUENCER_RETIRE_COUNTER_EN to enable the retired counter.
module stage_sequencer #(
  parameter int unsigned STALL_LIMIT = 255,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input logic             clk,
  input logic             reset,
  stage_sequencer_if.slave bus
);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_CLEAR      = 4'd1;
  localparam logic [3:0] S_FETCH      = 4'd2;
  localparam logic [3:0] S_DECODE     = 4'd3;
  localparam logic [3:0] S_EXECUTE    = 4'd4;
  localparam logic [3:0] S_MEMORY     = 4'd5;
  localparam logic [3:0] S_MEM_ACCESS = 4'd6;
  localparam logic [3:0] S_WRITEBACK  = 4'd7;
  localparam logic [3:0] S_COMMIT     = 4'd8;
  localparam logic [3:0] S_PAUSE      = 4'd9;
  localparam logic [3:0] S_HALT       = 4'd10;

  localparam int unsigned SW =
    (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT + 1) : 1;
  localparam logic [SW-1:0] LIMIT = SW'(STALL_LIMIT);

  logic [3:0]    state_q, state_d;
  logic [SW-1:0] stall_q, stall_d;
  logic [SW-1:0] stall_inc;
  logic          first_q, first_d;
  logic          err_q, err_d;

  assign stall_inc = stall_q + SW'(1);

  always_comb begin
    state_d = state_q;
    stall_d = stall_q;
    first_d = 1'b0;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_CLEAR;
        end
      end
      S_CLEAR:   state_d = S_FETCH;
      S_FETCH:   state_d = S_DECODE;
      S_DECODE:  state_d = S_EXECUTE;
      S_EXECUTE: state_d = S_MEMORY;
      S_MEMORY: begin
        state_d = S_MEM_ACCESS;
        stall_d = '0;
        first_d = 1'b1;
      end
      S_MEM_ACCESS: begin
        if (bus.mem_busy) begin
          stall_d = stall_inc;
          if (stall_inc == LIMIT) begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_WRITEBACK: state_d = S_COMMIT;
      S_COMMIT: begin
        if (bus.halt_req) begin
          state_d = S_HALT;
        end else if (!bus.run_en) begin
          state_d = S_PAUSE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_PAUSE: begin
        if (bus.run_en) begin
          state_d = S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      stall_q <= '0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      first_q <= first_d;
      err_q   <= err_d;
    end
  end

  // Outputs depend only on registered state, never on inputs.
  always_comb begin
    bus.pipe_clear = 1'b0;
    bus.if_id_we   = 1'b0;
    bus.id_ex_we   = 1'b0;
    bus.ex_mem_we  = 1'b0;
    bus.mem_wb_we  = 1'b0;
    bus.wb_if_we   = 1'b0;
    bus.ram_we     = 1'b0;
    bus.reg_we     = 1'b0;
    bus.halted     = 1'b0;
    case (state_q)
      S_CLEAR:      bus.pipe_clear = 1'b1;
      S_DECODE:     bus.if_id_we   = 1'b1;
      S_EXECUTE:    bus.id_ex_we   = 1'b1;
      S_MEMORY:     bus.ex_mem_we  = 1'b1;
      S_MEM_ACCESS: bus.ram_we     = first_q;
      S_WRITEBACK:  bus.mem_wb_we  = 1'b1;
      S_COMMIT: begin
        bus.reg_we   = 1'b1;
        bus.wb_if_we = 1'b1;
      end
      S_HALT:       bus.halted     = 1'b1;
      default: ;
    endcase
  end

  assign bus.stall_error = err_q;
  assign bus.state       = state_q;

`ifdef STAGE_SEQUENCER_RETIRE_COUNTER_EN
  logic [COUNT_WIDTH-1:0] retired_q, retired_d;

  // Saturating count of committed instructions.
  always_comb begin
    retired_d = retired_q;
    if (state_q == S_COMMIT && retired_q != '1) begin
      retired_d = retired_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign bus.retired_count = retired_q;
`else
  assign bus.retired_count = '0;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: sequencing, stalls, pause, halt, reset.
// Retired-count expectations follow STAGE_SEQUENCER_RETIRE_COUNTER_EN.
module tb_stage_sequencer;

  localparam int CW = 32;
`ifdef STAGE_SEQUENCER_RETIRE_COUNTER_EN
  localparam int RC = 1;
`else
  localparam int RC = 0;
`endif

  // {pipe_clear,if_id,id_ex,ex_mem,mem_wb,wb_if,ram_we,reg_we,halted,err}
  localparam logic [9:0] O_NONE = 10'b0000000000;
  localparam logic [9:0] O_CLR  = 10'b1000000000;
  localparam logic [9:0] O_DEC  = 10'b0100000000;
  localparam logic [9:0] O_EXE  = 10'b0010000000;
  localparam logic [9:0] O_MEM  = 10'b0001000000;
  localparam logic [9:0] O_WB   = 10'b0000100000;
  localparam logic [9:0] O_CMT  = 10'b0000010100;
  localparam logic [9:0] O_RAM  = 10'b0000001000;
  localparam logic [9:0] O_HLT  = 10'b0000000010;
  localparam logic [9:0] O_ERR  = 10'b0000000011;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  stage_sequencer_if #(.COUNT_WIDTH(CW)) bus ();
  stage_sequencer_if #(.COUNT_WIDTH(CW)) bus4 ();

  stage_sequencer #(
    .STALL_LIMIT(255),
    .COUNT_WIDTH(CW)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  stage_sequencer #(
    .STALL_LIMIT(4),
    .COUNT_WIDTH(CW)
  ) u_dut4 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus4.slave)
  );

  logic [9:0] outs, outs4;
  assign outs = {bus.pipe_clear, bus.if_id_we, bus.id_ex_we,
                 bus.ex_mem_we, bus.mem_wb_we, bus.wb_if_we,
                 bus.ram_we, bus.reg_we, bus.halted,
                 bus.stall_error};
  assign outs4 = {bus4.pipe_clear, bus4.if_id_we, bus4.id_ex_we,
                  bus4.ex_mem_we, bus4.mem_wb_we, bus4.wb_if_we,
                  bus4.ram_we, bus4.reg_we, bus4.halted,
                  bus4.stall_error};

  logic [3:0] seq_s [8] = '{4'd1, 4'd2, 4'd3, 4'd4,
                            4'd5, 4'd6, 4'd7, 4'd8};
  logic [9:0] seq_o [8] = '{O_CLR, O_NONE, O_DEC, O_EXE,
                            O_MEM, O_RAM, O_WB, O_CMT};

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  int ma, rw, lat;
  bit done;

  initial begin
    reset = 1'b1;
    bus.start = 0; bus.run_en = 0;
    bus.mem_busy = 0; bus.halt_req = 0;
    bus4.start = 0; bus4.run_en = 0;
    bus4.mem_busy = 0; bus4.halt_req = 0;
    step();
    step();
    reset = 1'b0;
    chk("rst_state", bus.state, 0);
    chk("rst_outs", outs, O_NONE);
    chk("rst_retired", bus.retired_count, 0);
    step();
    chk("idle_hold", bus.state, 0);

    // first instruction, no stalls
    bus.run_en = 1;
    bus.start = 1;
    step();
    bus.start = 0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("seq_state%0d", i), bus.state, seq_s[i]);
      chk($sformatf("seq_outs%0d", i), outs, seq_o[i]);
      if (i < 7) step();
    end
    chk("commit_retired_pre", bus.retired_count, 0);
    step();
    chk("refetch_state", bus.state, 2);
    chk("retired_1", bus.retired_count, 64'(RC));

    // five busy cycles in MEM_ACCESS
    bus.mem_busy = 1;
    ma = 0; rw = 0; lat = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      lat++;
      if (bus.state == 4'd6) begin
        ma++;
        if (ma == 6) bus.mem_busy = 0;
      end
      if (bus.ram_we) rw++;
      if (bus.reg_we) done = 1;
    end
    bus.mem_busy = 0;
    chk("stall_commit_seen", done, 1);
    chk("stall_ma_cycles", ma, 6);
    chk("stall_ram_we_cycles", rw, 1);
    chk("stall_commit_lat", lat, 11);
    chk("stall_commit_state", bus.state, 8);

    // pause, with start ignored
    bus.run_en = 0;
    step();
    chk("retired_2", bus.retired_count, 64'(2 * RC));
    bus.start = 1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("pause_state%0d", i), bus.state, 9);
      chk($sformatf("pause_outs%0d", i), outs, O_NONE);
      step();
    end
    chk("pause_still", bus.state, 9);
    bus.start = 0;
    bus.run_en = 1;
    step();
    chk("pause_resume", bus.state, 2);

    // halt wins over pause
    repeat (6) step();
    chk("halt_commit_state", bus.state, 8);
    chk("halt_commit_outs", outs, O_CMT);
    bus.halt_req = 1;
    bus.run_en = 0;
    step();
    chk("halt_state", bus.state, 10);
    chk("halt_outs", outs, O_HLT);
    bus.start = 1;
    bus.halt_req = 0;
    bus.run_en = 1;
    repeat (3) step();
    chk("halt_sticky_state", bus.state, 10);
    chk("halt_sticky_outs", outs, O_HLT);
    chk("retired_3", bus.retired_count, 64'(3 * RC));
    bus.start = 0;

    // reset in the middle of a stall
    reset = 1;
    step();
    reset = 0;
    chk("rst2_state", bus.state, 0);
    bus.run_en = 1;
    bus.start = 1;
    step();
    bus.start = 0;
    repeat (7) step();
    chk("rst2_commit", bus.state, 8);
    bus.mem_busy = 1;
    repeat (7) step();
    chk("rst2_in_stall", bus.state, 6);
    chk("rst2_retired_pre", bus.retired_count, 64'(RC));
    reset = 1;
    step();
    reset = 0;
    bus.mem_busy = 0;
    chk("rst2_after_state", bus.state, 0);
    chk("rst2_after_outs", outs, O_NONE);
    chk("rst2_after_retired", bus.retired_count, 0);

    // stall limit of 4 on the second instance
    bus4.run_en = 1;
    bus4.mem_busy = 1;
    bus4.start = 1;
    step();
    bus4.start = 0;
    chk("lim_clear", bus4.state, 1);
    ma = 0; done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      step();
      if (bus4.state == 4'd6) ma++;
      if (bus4.state == 4'd10) done = 1;
    end
    chk("lim_halt_seen", done, 1);
    chk("lim_ma_cycles", ma, 4);
    chk("lim_state", bus4.state, 10);
    chk("lim_outs", outs4, O_ERR);
    repeat (5) step();
    chk("lim_hold_state", bus4.state, 10);
    chk("lim_hold_outs", outs4, O_ERR);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
